// File: rtl/prog_chain_loader_if.sv
// Byte stream from the host into the loader plus the readback strobe back out.
interface prog_chain_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] rb_byte;
    logic       rb_valid;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  rb_byte,
        input  rb_valid
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output rb_byte,
        output rb_valid
    );
endinterface

// File: rtl/prog_chain_loader.sv
// Serial configuration chain loader: takes bitstream bytes, shifts them
// MSB-first into the fabric chain at a divided clock rate and returns the
// bits that fall out of the chain tail as readback bytes.
module prog_chain_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    prog_chain_loader_if.slave bus,
    output logic              prog_clk_o,
    output logic              prog_en_o,
    output logic              prog_in_o,
    input  logic              prog_out_i,
    output logic              busy,
    output logic              done
);

    localparam int unsigned   CW       = $clog2(CHAIN_LEN + 1);
    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned   TAIL     = CHAIN_LEN % 8;
    localparam int unsigned   PAD      = (TAIL == 0) ? 0 : 8 - TAIL;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

    state_t        state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [CW-1:0] bit_cnt_d;
    logic [2:0]    bib_q;       // bit position within the current byte
    logic [DW-1:0] div_q;
    logic [6:0]    sr_q;        // remaining bits of the current byte; MSB is already on prog_in
    logic [6:0]    sr_d;
    logic [7:0]    acc_q;
    logic [7:0]    acc_d;

    logic          prog_clk_q;
    logic          prog_en_q;
    logic          prog_in_q;
    logic          busy_q;
    logic          done_q;
    logic          ready_q;
    logic          rb_valid_q;
    logic [7:0]    rb_byte_q;

    // Next values for the data path registers.
    always_comb begin
        acc_d     = {acc_q[6:0], prog_out_i};
        sr_d      = {sr_q[5:0], 1'b0};
        bit_cnt_d = bit_cnt_q + CW'(1);
    end

    // Load sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bib_q      <= '0;
            div_q      <= '0;
            sr_q       <= '0;
            acc_q      <= '0;
            prog_clk_q <= 1'b0;
            prog_en_q  <= 1'b0;
            prog_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            rb_valid_q <= 1'b0;
            rb_byte_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rb_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        busy_q    <= 1'b1;
                        prog_en_q <= 1'b1;
                        ready_q   <= 1'b1;
                        bit_cnt_q <= '0;
                        bib_q     <= '0;
                        acc_q     <= '0;
                    end
                end
                FETCH: begin
                    if (bus.byte_valid && ready_q) begin
                        sr_q      <= bus.byte_in[6:0];
                        prog_in_q <= bus.byte_in[7];
                        ready_q   <= 1'b0;
                        div_q     <= '0;
                        state_q   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_q == DIV_LAST) begin
                        div_q      <= '0;
                        acc_q      <= acc_d;
                        prog_clk_q <= 1'b1;
                        state_q    <= SHIFT_HI;
                        if (bib_q == 3'd7) begin
                            rb_valid_q <= 1'b1;
                            rb_byte_q  <= acc_d;
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_q == DIV_LAST) begin
                        div_q      <= '0;
                        bit_cnt_q  <= bit_cnt_d;
                        bib_q      <= bib_q + 3'd1;
                        sr_q       <= sr_d;
                        prog_clk_q <= 1'b0;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q   <= FINISH;
                            prog_en_q <= 1'b0;
                            prog_in_q <= 1'b0;
                            done_q    <= 1'b1;
                            // Partial last group: keep only the bits of this
                            // byte, left-aligned, zero below.
                            if (TAIL != 0) begin
                                rb_valid_q <= 1'b1;
                                rb_byte_q  <= acc_q << PAD;
                            end
                        end else if (bib_q == 3'd7) begin
                            state_q <= FETCH;
                            ready_q <= 1'b1;
                        end else begin
                            state_q   <= SHIFT_LO;
                            prog_in_q <= sr_q[6];
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign prog_clk_o     = prog_clk_q;
    assign prog_en_o      = prog_en_q;
    // Data into the chain head must be low whenever programming is disabled.
    assign prog_in_o      = prog_in_q & prog_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bus.byte_ready = ready_q;
    assign bus.rb_valid   = rb_valid_q;
    assign bus.rb_byte    = rb_byte_q;

endmodule

// File: tb/tb_prog_chain_loader.sv
// Bench for prog_chain_loader: three instances (16/1, 12/1, 16/3), each with
// a behavioural configuration chain on its prog_* pins.
module tb_prog_chain_loader;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a    [ND];
    logic [7:0] byte_in_a  [ND];
    logic       valid_a    [ND];
    logic       ready_a    [ND];
    logic [7:0] rb_byte_a  [ND];
    logic       rb_valid_a [ND];
    logic       pclk_a     [ND];
    logic       pen_a      [ND];
    logic       pin_a      [ND];
    logic       pout_a     [ND];
    logic       busy_a     [ND];
    logic       done_a     [ND];
    logic       load_a     [ND];
    logic [15:0] preload_a [ND];
    logic [15:0] chain_a   [ND];

    int total;
    int bad;

    // Model state (written only by the monitor).
    bit         exp_bits [ND][$];
    logic [7:0] exp_rb   [ND][$];
    int   edges [ND];
    int   bytes [ND];
    int   dones [ND];
    int   hi_len [ND];
    int   lo_len [ND];
    int   rb_cnt [ND];
    logic [7:0] rb_first [ND];
    logic [7:0] rb_last  [ND];
    logic p_clk [ND];
    logic p_en  [ND];
    logic p_in  [ND];
    logic p_rdy [ND];
    bit   busy_chk [ND];

    function automatic int len_of(input int d);
        return (d == 1) ? 12 : 16;
    endfunction

    function automatic int div_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic string nm(input int d, input string s);
        return $sformatf("d%0d_%s", d, s);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : gen_dut
        localparam int unsigned L  = (g == 1) ? 12 : 16;
        localparam int unsigned DV = (g == 2) ? 3 : 1;

        prog_chain_loader_if bus ();
        logic [15:0] chain;
        logic        pclk_prev;

        assign bus.byte_in    = byte_in_a[g];
        assign bus.byte_valid = valid_a[g];
        assign ready_a[g]     = bus.byte_ready;
        assign rb_byte_a[g]   = bus.rb_byte;
        assign rb_valid_a[g]  = bus.rb_valid;

        prog_chain_loader #(.CHAIN_LEN(L), .CLK_DIV(DV)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start_a[g]),
            .bus        (bus),
            .prog_clk_o (pclk_a[g]),
            .prog_en_o  (pen_a[g]),
            .prog_in_o  (pin_a[g]),
            .prog_out_i (pout_a[g]),
            .busy       (busy_a[g]),
            .done       (done_a[g])
        );

        // Chain model: shifts toward the tail once per prog_clk rising edge.
        always @(posedge clk) begin
            if (load_a[g]) chain <= preload_a[g];
            else if (pclk_a[g] && !pclk_prev) chain <= {chain[14:0], pin_a[g]};
            pclk_prev <= pclk_a[g];
        end
        assign pout_a[g]  = chain[L-1];
        assign chain_a[g] = chain;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int d);
        int L;
        int DV;
        int rem;
        int n;
        logic [7:0] acc;
        bit b;
        L  = len_of(d);
        DV = div_of(d);
        if (!rst_n) begin
            check(nm(d, "rst_outs"), {busy_a[d], done_a[d], pen_a[d], pclk_a[d], pin_a[d],
                  ready_a[d], rb_valid_a[d], rb_byte_a[d]}, 0);
            exp_bits[d].delete();
            exp_rb[d].delete();
            edges[d] = 0; bytes[d] = 0; hi_len[d] = 0; lo_len[d] = 0; busy_chk[d] = 0;
            p_clk[d] = 0; p_en[d] = 0; p_in[d] = 0; p_rdy[d] = 0;
            return;
        end
        if (start_a[d] && !busy_a[d]) begin
            exp_bits[d].delete();
            exp_rb[d].delete();
            edges[d] = 0; bytes[d] = 0; dones[d] = 0; rb_cnt[d] = 0;
            acc = '0;
            for (int i = 0; i < L; i++) begin
                acc = {acc[6:0], chain_a[d][L-1-i]};
                if (i % 8 == 7) begin
                    exp_rb[d].push_back(acc);
                    acc = '0;
                end
            end
            if (L % 8 != 0) exp_rb[d].push_back(acc << (8 - L % 8));
        end
        if (valid_a[d] && ready_a[d]) begin
            check(nm(d, "byte_in_budget"), bytes[d] < (L + 7) / 8, 1);
            rem = L - 8 * bytes[d];
            n = (rem < 8) ? rem : 8;
            for (int j = 0; j < n; j++) exp_bits[d].push_back(byte_in_a[d][7-j]);
            bytes[d]++;
        end
        if (pclk_a[d] && !p_clk[d]) begin
            check(nm(d, "edge_has_data"), exp_bits[d].size() > 0, 1);
            if (exp_bits[d].size() > 0) begin
                b = exp_bits[d].pop_front();
                check(nm(d, "bit_at_edge"), pin_a[d], b);
            end
            check(nm(d, "low_width"), lo_len[d], DV);
            edges[d]++;
        end
        if (pclk_a[d]) begin
            hi_len[d]++;
            check(nm(d, "en_while_clk"), pen_a[d], 1);
        end
        if (!pclk_a[d] && p_clk[d]) begin
            check(nm(d, "high_width"), hi_len[d], DV);
            hi_len[d] = 0;
        end
        if (!pclk_a[d] && pen_a[d] && !ready_a[d]) lo_len[d]++;
        else lo_len[d] = 0;
        if (!pen_a[d]) check(nm(d, "in_low_when_dis"), pin_a[d], 0);
        if (pen_a[d] && p_en[d] && pin_a[d] !== p_in[d])
            check(nm(d, "in_change_slot"), p_clk[d] || p_rdy[d], 1);
        if (ready_a[d]) check(nm(d, "fetch_busy_en"), busy_a[d] && pen_a[d], 1);
        if (rb_valid_a[d]) begin
            check(nm(d, "rb_expected"), exp_rb[d].size() > 0, 1);
            if (exp_rb[d].size() > 0) check(nm(d, "rb_byte"), rb_byte_a[d], exp_rb[d].pop_front());
            if (rb_cnt[d] == 0) rb_first[d] = rb_byte_a[d];
            rb_last[d] = rb_byte_a[d];
            rb_cnt[d]++;
        end
        if (busy_chk[d]) begin
            check(nm(d, "busy_after_done"), busy_a[d], 0);
            busy_chk[d] = 0;
        end
        if (done_a[d]) begin
            check(nm(d, "done_edges"), edges[d], L);
            check(nm(d, "done_bits_left"), exp_bits[d].size(), 0);
            check(nm(d, "done_rb_left"), exp_rb[d].size(), 0);
            check(nm(d, "done_busy"), busy_a[d], 1);
            dones[d]++;
            busy_chk[d] = 1;
        end
        p_clk[d] = pclk_a[d];
        p_en[d]  = pen_a[d];
        p_in[d]  = pin_a[d];
        p_rdy[d] = ready_a[d];
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) step(d);
        end
    endtask

    task automatic preload(input int d, input logic [15:0] v);
        @(posedge clk); #1;
        preload_a[d] = v;
        load_a[d] = 1'b1;
        @(posedge clk); #1;
        load_a[d] = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1 start_a[d] = 1'b1;
        @(posedge clk); #1 start_a[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b);
        bit ok;
        ok = 0;
        byte_in_a[d] = b;
        valid_a[d] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready_a[d]) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        valid_a[d] = 1'b0;
        byte_in_a[d] = '0;
        check(nm(d, "byte_accepted"), ok, 1);
    endtask

    task automatic wait_done(input int d);
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done_a[d]) begin
                ok = 1;
                break;
            end
        end
        check(nm(d, "done_seen"), ok, 1);
        @(negedge clk); #1;
        check(nm(d, "idle_after"), busy_a[d], 0);
    endtask

    task automatic run_load(input int d, input logic [7:0] b0, input logic [7:0] b1,
                            input int gap, input bit mid_start);
        bit ok;
        pulse_start(d);
        send_byte(d, b0);
        if (gap > 0) begin
            ok = 0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk); #2;
                if (ready_a[d]) begin
                    ok = 1;
                    break;
                end
            end
            check(nm(d, "bp_fetch_reached"), ok, 1);
            repeat (gap) begin
                @(posedge clk); #2;
                check(nm(d, "bp_ready"), ready_a[d], 1);
                check(nm(d, "bp_clk_low"), pclk_a[d], 0);
                check(nm(d, "bp_en"), pen_a[d], 1);
            end
        end
        if (mid_start) pulse_start(d);
        send_byte(d, b1);
        wait_done(d);
    endtask

    initial begin
        bit ok;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            start_a[d] = 0; valid_a[d] = 0; byte_in_a[d] = '0;
            load_a[d] = 0; preload_a[d] = '0;
            dones[d] = 0; rb_cnt[d] = 0; rb_first[d] = '0; rb_last[d] = '0;
        end
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            check(nm(d, "reset_state"), {busy_a[d], done_a[d], pen_a[d], pclk_a[d],
                  pin_a[d], ready_a[d], rb_valid_a[d]}, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // 16 bits, div 1: A5 3C over a chain holding BEEF.
        preload(0, 16'hBEEF);
        run_load(0, 8'hA5, 8'h3C, 0, 0);
        check("d0_chain_after", chain_a[0], 16'hA53C);
        check("d0_rb_first", rb_first[0], 8'hBE);
        check("d0_rb_last", rb_last[0], 8'hEF);
        check("d0_rb_count", rb_cnt[0], 2);
        check("d0_edges", edges[0], 16);
        check("d0_dones", dones[0], 1);

        // 12 bits: last byte only contributes its upper nibble.
        preload(1, 16'h0ABC);
        run_load(1, 8'hF0, 8'hAB, 0, 0);
        check("d1_chain_after", chain_a[1][11:0], 12'hF0A);
        check("d1_edges", edges[1], 12);
        check("d1_bytes", bytes[1], 2);
        check("d1_rb_first", rb_first[1], 8'hAB);
        check("d1_rb_last", rb_last[1], 8'hC0);

        // Host stalls 20 cycles between bytes.
        preload(0, 16'h1234);
        run_load(0, 8'h5A, 8'hC3, 20, 0);
        check("d0_bp_chain", chain_a[0], 16'h5AC3);
        check("d0_bp_rb_first", rb_first[0], 8'h12);
        check("d0_bp_rb_last", rb_last[0], 8'h34);

        // Divide by 3 with a stray start while busy.
        preload(2, 16'hFACE);
        run_load(2, 8'h96, 8'h69, 0, 1);
        check("d2_chain_after", chain_a[2], 16'h9669);
        check("d2_rb_first", rb_first[2], 8'hFA);
        check("d2_rb_last", rb_last[2], 8'hCE);
        check("d2_dones", dones[2], 1);
        check("d2_edges", edges[2], 16);

        // Reset in the middle of the 5th bit, then a clean reload.
        preload(0, 16'hBEEF);
        pulse_start(0);
        send_byte(0, 8'hA5);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (edges[0] == 4 && !pclk_a[0]) begin
                ok = 1;
                break;
            end
        end
        check("d0_reached_bit5", ok, 1);
        rst_n = 1'b0;
        #1;
        check("d0_rst_en", pen_a[0], 0);
        check("d0_rst_clk", pclk_a[0], 0);
        check("d0_rst_busy", busy_a[0], 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        preload(0, 16'hBEEF);
        run_load(0, 8'hA5, 8'h3C, 0, 0);
        check("d0_rl_chain", chain_a[0], 16'hA53C);
        check("d0_rl_rb_first", rb_first[0], 8'hBE);
        check("d0_rl_rb_last", rb_last[0], 8'hEF);
        check("d0_rl_edges", edges[0], 16);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
